yarp_lsu_wb: RTL



---
 rtl/yarp_lsu_wb_pkg.sv | 61 ++++++
 rtl/yarp_lsu_wb_if.sv | 36 +++
 rtl/yarp_lsu_wb_load_extract.sv | 35 +++
 rtl/yarp_lsu_wb.sv | 123 ++++++++++++
 4 files changed

// File: rtl/yarp_lsu_wb_pkg.sv
// Shared types and lane helpers for the YARP load/store writeback unit.
// Access sizes, FSM states and byte-lane math live here.
package yarp_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } lsu_state_t;

    function automatic logic is_illegal(
        input logic [1:0] size,
        input logic [1:0] off,
        input logic       ld,
        input logic       st
    );
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            (ld & st):                    bad = 1'b1;
            (size == 2'b11):              bad = 1'b1;
            (size == HALF) && off[0]:     bad = 1'b1;
            (size == WORD) && (off != 0): bad = 1'b1;
            default:                      bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_en(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        unique case (size)
            BYTE:    be = 4'b0001 << off;
            HALF:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(
        input logic [1:0]  size,
        input logic [31:0] d
    );
        logic [31:0] w;
        unique case (size)
            BYTE:    w = {4{d[7:0]}};
            HALF:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/yarp_lsu_wb_if.sv
// Data-memory req/gnt/rvalid bus between the LSU and memory.
// The LSU side is master; memory is slave.
interface yarp_lsu_wb_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_byte_en_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        output mem_byte_en_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_byte_en_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/yarp_lsu_wb_load_extract.sv
// Load data alignment: shift the addressed lane down, truncate, extend.
// Purely combinational.
module yarp_load_extract
    import yarp_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] value
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        value   = shifted;
        unique case (size)
            BYTE: begin
                if (zero_ext)
                    value = {24'h0, shifted[7:0]};
                else
                    value = {{24{shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                if (zero_ext)
                    value = {16'h0, shifted[15:0]};
                else
                    value = {{16{shifted[15]}}, shifted[15:0]};
            end
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/yarp_lsu_wb.sv
// YARP load/store + writeback unit: drives the data-memory bus and
// the register file write port, stalling upstream while a load/store runs.
module yarp_lsu_wb
    import yarp_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid_i,
    input  logic               ex_load_i,
    input  logic               ex_store_i,
    input  logic [1:0]         ex_size_i,
    input  logic               ex_zero_ext_i,
    input  logic [31:0]        ex_addr_i,
    input  logic [31:0]        ex_store_data_i,
    input  logic [31:0]        ex_alu_res_i,
    input  logic [4:0]         ex_rd_addr_i,
    input  logic               ex_rd_wr_en_i,
    yarp_lsu_wb_if.master      mem,
    output logic               busy_o,
    output logic [4:0]         rd_addr_o,
    output logic               wr_en_o,
    output logic [31:0]        wr_data_o,
    output logic               misaligned_o
);

    lsu_state_t  state;
    logic [1:0]  ld_off;
    logic [1:0]  ld_size;
    logic        ld_zext;
    logic [4:0]  ld_rd;
    logic        ld_wr;
    logic [31:0] ext_val;
    logic        is_mem;
    logic        bad;

    assign is_mem = ex_load_i | ex_store_i;
    assign bad    = is_illegal(ex_size_i, ex_addr_i[1:0],
                               ex_load_i, ex_store_i);

    yarp_load_extract u_extract (
        .rdata    (mem.mem_rdata_i),
        .addr     (ld_off),
        .size     (ld_size),
        .zero_ext (ld_zext),
        .value    (ext_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            busy_o            <= 1'b0;
            rd_addr_o         <= 5'd0;
            wr_en_o           <= 1'b0;
            wr_data_o         <= 32'h0;
            misaligned_o      <= 1'b0;
            mem.mem_req_o     <= 1'b0;
            mem.mem_we_o      <= 1'b0;
            mem.mem_addr_o    <= 32'h0;
            mem.mem_wdata_o   <= 32'h0;
            mem.mem_byte_en_o <= 4'h0;
            ld_off            <= 2'b00;
            ld_size           <= 2'b00;
            ld_zext           <= 1'b0;
            ld_rd             <= 5'd0;
            ld_wr             <= 1'b0;
        end else begin
            wr_en_o      <= 1'b0;
            misaligned_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ex_valid_i && is_mem && bad) begin
                        misaligned_o <= 1'b1;
                    end else if (ex_valid_i && is_mem) begin
                        state             <= REQ;
                        busy_o            <= 1'b1;
                        mem.mem_req_o     <= 1'b1;
                        mem.mem_we_o      <= ex_store_i;
                        mem.mem_addr_o    <= {ex_addr_i[31:2], 2'b00};
                        mem.mem_wdata_o   <= lane_data(ex_size_i,
                                                       ex_store_data_i);
                        mem.mem_byte_en_o <= lane_en(ex_size_i,
                                                     ex_addr_i[1:0]);
                        ld_off            <= ex_addr_i[1:0];
                        ld_size           <= ex_size_i;
                        ld_zext           <= ex_zero_ext_i;
                        ld_rd             <= ex_rd_addr_i;
                        ld_wr             <= ex_rd_wr_en_i &&
                                             (ex_rd_addr_i != 5'd0);
                    end else if (ex_valid_i && ex_rd_wr_en_i) begin
                        wr_en_o   <= (ex_rd_addr_i != 5'd0);
                        wr_data_o <= ex_alu_res_i;
                        rd_addr_o <= ex_rd_addr_i;
                    end
                end
                REQ: begin
                    if (mem.mem_gnt_i) begin
                        mem.mem_req_o <= 1'b0;
                        if (mem.mem_we_o) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid_i) begin
                        state     <= IDLE;
                        busy_o    <= 1'b0;
                        wr_en_o   <= ld_wr;
                        wr_data_o <= ext_val;
                        rd_addr_o <= ld_rd;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
